// File: rtl/wm8731_pkg.sv
// Shared types and constants for the WM8731 two-wire control port model.
package wm8731_pkg;

  // WM8731 with CSB tied low answers at write byte 0x34.
  localparam logic [6:0] WM8731_ADDR = 7'b0011010;

  // Control word fields: 7-bit register address, 9-bit register value.
  localparam int REG_AW = 7;
  localparam int REG_DW = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK_A,
    ST_BYTE1,
    ST_ACK_1,
    ST_BYTE2,
    ST_ACK_2,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizers for SCL/SDA plus registered edge, START and STOP
// detection. Every flag and sda_s refer to the same sampled instant, three
// clk cycles after the pin moves.
module i2c_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic scl_m, scl_y, scl_q;
  logic sda_m, sda_y, sda_q;

  // Metastability filter; idle bus level is high, so reset to 1 to avoid
  // phantom edges when reset is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_m <= 1'b1;
      scl_y <= 1'b1;
      sda_m <= 1'b1;
      sda_y <= 1'b1;
    end else begin
      scl_m <= scl;
      scl_y <= scl_m;
      sda_m <= sda;
      sda_y <= sda_m;
    end
  end

  // Edge register: compare the synchronized level with its previous value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      sda_s     <= 1'b1;
    end else begin
      scl_q     <= scl_y;
      sda_q     <= sda_y;
      scl_rise  <= scl_y & ~scl_q;
      scl_fall  <= ~scl_y & scl_q;
      // SDA moving while SCL is steadily high is a bus condition, not data.
      start_det <= scl_y & scl_q & sda_q & ~sda_y;
      stop_det  <= scl_y & scl_q & ~sda_q & sda_y;
      sda_s     <= sda_y;
    end
  end

endmodule

// File: rtl/wm8731_i2c_responder.sv
// Write-only I2C target modelling the WM8731 control port. Accepts
// address + two data bytes and presents them as a 7-bit register address
// and 9-bit register value with a one-cycle write strobe.
module wm8731_i2c_responder
  import wm8731_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = WM8731_ADDR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i2c_sclk,
  inout  wire               i2c_sdat,
  output logic [REG_AW-1:0] reg_addr,
  output logic [REG_DW-1:0] reg_data,
  output logic              reg_wr,
  output logic              busy,
  output logic              addr_nack
);

  logic       scl_rise, scl_fall, start_det, stop_det, sda_s;
  state_t     state, state_nx;
  logic [2:0] bit_cnt;
  logic       byte_full;
  logic [7:0] shreg;
  logic [7:0] byte1;
  logic       addr_match;
  logic       byte_end;
  logic       shift_en;
  logic       cnt_clr;
  logic       wr_nx;
  logic       nack_nx;
  logic       byte1_ld;
  logic       ack_drive;

  i2c_line_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl       (i2c_sclk),
    .sda       (i2c_sdat),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  assign addr_match = (shreg[7:1] == DEV_ADDR) && (shreg[0] == 1'b0);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state: bus conditions override everything; a completed byte is
  // acted on at the SCL fall that ends its 8th bit, an ACK ends at the
  // SCL fall that ends the 9th clock.
  always_comb begin
    state_nx = state;
    if (start_det) begin
      state_nx = ST_ADDR;
    end else if (stop_det) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_ADDR:  if (scl_fall && byte_full) state_nx = addr_match ? ST_ACK_A : ST_IGNORE;
        ST_ACK_A: if (scl_fall)              state_nx = ST_BYTE1;
        ST_BYTE1: if (scl_fall && byte_full) state_nx = ST_ACK_1;
        ST_ACK_1: if (scl_fall)              state_nx = ST_BYTE2;
        ST_BYTE2: if (scl_fall && byte_full) state_nx = ST_ACK_2;
        ST_ACK_2: if (scl_fall)              state_nx = ST_IGNORE;
        default:  state_nx = state;
      endcase
    end
  end

  // Output/control decode from the current state and detector flags.
  always_comb begin
    byte_end  = scl_fall && byte_full && !start_det && !stop_det;
    shift_en  = 1'b0;
    nack_nx   = 1'b0;
    wr_nx     = 1'b0;
    byte1_ld  = 1'b0;
    ack_drive = 1'b0;
    cnt_clr   = start_det || stop_det || (state_nx != state);
    case (state)
      ST_ADDR: begin
        shift_en = scl_rise && !byte_full;
        nack_nx  = byte_end && !addr_match;
      end
      ST_BYTE1: begin
        shift_en = scl_rise && !byte_full;
        byte1_ld = byte_end;
      end
      ST_BYTE2: begin
        shift_en = scl_rise && !byte_full;
        wr_nx    = byte_end;
      end
      ST_ACK_A, ST_ACK_1, ST_ACK_2: ack_drive = 1'b1;
      default: ;
    endcase
    if (start_det || stop_det) shift_en = 1'b0;
  end

  // Open-drain pin: state is registered, so the low drive starts one cycle
  // after the fall is detected; reset releases the line without waiting
  // for a clock.
  assign i2c_sdat = (ack_drive && reset) ? 1'b0 : 1'bz;

  // Bit assembly, captured bytes, strobes and busy flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt   <= 3'd0;
      byte_full <= 1'b0;
      shreg     <= 8'd0;
      byte1     <= 8'd0;
      reg_addr  <= '0;
      reg_data  <= '0;
      reg_wr    <= 1'b0;
      addr_nack <= 1'b0;
      busy      <= 1'b0;
    end else begin
      reg_wr    <= wr_nx;
      addr_nack <= nack_nx;
      if (start_det)     busy <= 1'b1;
      else if (stop_det) busy <= 1'b0;
      if (cnt_clr) begin
        bit_cnt   <= 3'd0;
        byte_full <= 1'b0;
      end else if (shift_en) begin
        shreg   <= {shreg[6:0], sda_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) byte_full <= 1'b1;
      end
      if (byte1_ld) byte1 <= shreg;
      if (wr_nx) begin
        reg_addr <= byte1[7:1];
        reg_data <= {byte1[0], shreg};
      end
    end
  end

endmodule

// File: tb/tb_wm8731_i2c_responder.sv
// Directed bench: bit-banged I2C controller driving the responder.
module tb_wm8731_i2c_responder;

  localparam int Q = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  wire        sdat;
  logic [6:0] reg_addr;
  logic [8:0] reg_data;
  logic       reg_wr;
  logic       busy;
  logic       addr_nack;

  int         n_vec = 0;
  int         n_err = 0;
  int         wr_cnt = 0;
  int         nack_cnt = 0;
  int         drv_cnt = 0;
  int         wr0, nk0, dv0;
  logic [6:0] cap_addr = 7'd0;
  logic [8:0] cap_data = 9'd0;
  logic       ack;

  assign sdat = m_sda ? 1'bz : 1'b0;
  pullup (sdat);

  always #5 clk = ~clk;

  wm8731_i2c_responder dut (
    .clk       (clk),
    .reset     (reset),
    .i2c_sclk  (m_scl),
    .i2c_sdat  (sdat),
    .reg_addr  (reg_addr),
    .reg_data  (reg_data),
    .reg_wr    (reg_wr),
    .busy      (busy),
    .addr_nack (addr_nack)
  );

  // Passive observer on the inactive edge.
  always @(negedge clk) begin
    if (reg_wr) begin
      wr_cnt   = wr_cnt + 1;
      cap_addr = reg_addr;
      cap_data = reg_data;
    end
    if (addr_nack) nack_cnt = nack_cnt + 1;
    if (m_sda && sdat === 1'b0) drv_cnt = drv_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wq(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    wr0 = wr_cnt;
    nk0 = nack_cnt;
    dv0 = drv_cnt;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wq(Q);
    m_scl = 1'b1; wq(Q);
    m_sda = 1'b0; wq(Q);
    m_scl = 1'b0; wq(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wq(Q);
    m_scl = 1'b1; wq(Q);
    m_sda = 1'b1; wq(Q);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;    wq(Q);
    m_scl = 1'b1; wq(2 * Q);
    m_scl = 1'b0; wq(Q);
  endtask

  task automatic get_ack(output logic a);
    m_sda = 1'b1; wq(Q);
    m_scl = 1'b1; wq(Q);
    a = (sdat === 1'b0);
    wq(Q);
    m_scl = 1'b0; wq(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic a);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    get_ack(a);
  endtask

  initial begin
    // Reset state
    wq(5);
    chk("rst_sdat", sdat, 1'b1);
    chk("rst_addr", reg_addr, 7'h00);
    chk("rst_data", reg_data, 9'h000);
    chk("rst_wr", reg_wr, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_nack", addr_nack, 1'b0);
    reset = 1'b1;
    wq(5);

    // Valid frame 0x34 0x1E 0x00
    snap();
    i2c_start();
    chk("v_busy_hi", busy, 1'b1);
    send_byte(8'h34, ack); chk("v_ack_a", ack, 1'b1);
    send_byte(8'h1E, ack); chk("v_ack_1", ack, 1'b1);
    send_byte(8'h00, ack); chk("v_ack_2", ack, 1'b1);
    i2c_stop();
    wq(10);
    chk("v_wr_cnt", wr_cnt - wr0, 1);
    chk("v_addr", cap_addr, 7'h0F);
    chk("v_data", cap_data, 9'h000);
    chk("v_busy_lo", busy, 1'b0);
    chk("v_addr_held", reg_addr, 7'h0F);
    chk("v_nack_cnt", nack_cnt - nk0, 0);

    // Address mismatch 0xAA 0x3C 0xC3
    snap();
    i2c_start();
    send_byte(8'hAA, ack); chk("m_ack_a", ack, 1'b0);
    send_byte(8'h3C, ack); chk("m_ack_1", ack, 1'b0);
    send_byte(8'hC3, ack); chk("m_ack_2", ack, 1'b0);
    i2c_stop();
    wq(10);
    chk("m_nack_cnt", nack_cnt - nk0, 1);
    chk("m_drive", drv_cnt - dv0, 0);
    chk("m_wr_cnt", wr_cnt - wr0, 0);

    // Read request 0x35
    snap();
    i2c_start();
    send_byte(8'h35, ack); chk("r_ack_a", ack, 1'b0);
    send_byte(8'h00, ack); chk("r_ack_1", ack, 1'b0);
    i2c_stop();
    wq(10);
    chk("r_nack_cnt", nack_cnt - nk0, 1);
    chk("r_drive", drv_cnt - dv0, 0);
    chk("r_wr_cnt", wr_cnt - wr0, 0);

    // Early STOP after 0x34 0x08
    snap();
    i2c_start();
    send_byte(8'h34, ack); chk("e_ack_a", ack, 1'b1);
    send_byte(8'h08, ack); chk("e_ack_1", ack, 1'b1);
    i2c_stop();
    wq(10);
    chk("e_wr_cnt", wr_cnt - wr0, 0);
    chk("e_busy", busy, 1'b0);
    chk("e_nack_cnt", nack_cnt - nk0, 0);

    // Repeated START discards partial frame
    snap();
    i2c_start();
    send_byte(8'h34, ack);
    send_byte(8'h08, ack);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    i2c_start();
    send_byte(8'h34, ack); chk("s_ack_a", ack, 1'b1);
    send_byte(8'h08, ack); chk("s_ack_1", ack, 1'b1);
    send_byte(8'h12, ack); chk("s_ack_2", ack, 1'b1);
    i2c_stop();
    wq(10);
    chk("s_wr_cnt", wr_cnt - wr0, 1);
    chk("s_addr", cap_addr, 7'h04);
    chk("s_data", cap_data, 9'h012);

    // Reset asserted while ACK_A holds the line low
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(8'h34 >> i);
    m_sda = 1'b1;
    wq(Q);
    chk("x_ack_low", sdat, 1'b0);
    reset = 1'b0;
    #1;
    chk("x_sdat_rel", sdat, 1'b1);
    chk("x_busy", busy, 1'b0);
    chk("x_addr", reg_addr, 7'h00);
    chk("x_data", reg_data, 9'h000);
    chk("x_wr", reg_wr, 1'b0);
    chk("x_nack", addr_nack, 1'b0);
    wq(3);
    reset = 1'b1;
    wq(5);
    snap();
    i2c_start();
    send_byte(8'h34, ack); chk("y_ack_a", ack, 1'b1);
    send_byte(8'h0F, ack); chk("y_ack_1", ack, 1'b1);
    send_byte(8'hA5, ack); chk("y_ack_2", ack, 1'b1);
    i2c_stop();
    wq(10);
    chk("y_wr_cnt", wr_cnt - wr0, 1);
    chk("y_addr", cap_addr, 7'h07);
    chk("y_data", cap_data, 9'h1A5);
    chk("y_busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wm8731_i2c_responder.md
# wm8731_i2c_responder

I2C write-only responder modelling the WM8731 two-wire control port. It is the target end of the link driven by the `i2cc` controller. It watches `i2c_sclk`/`i2c_sdat` on the system clock, acknowledges frames addressed to `DEV_ADDR`, and reassembles each 3-byte frame into a 7-bit register address and 9-bit register value. It serves as the codec-side model in benches and as a register-capture block in loopback builds.

## Interface
- `DEV_ADDR`, default `7'b0011010`: 7-bit device address (WM8731 with CSB=0, write byte `0x34`).
- `clk`  in  1: system clock; all logic is sampled on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `i2c_sclk`  in  1: bus clock from the controller; asynchronous to `clk`.
- `i2c_sdat`  inout  1: open-drain data. The block drives only `1'b0` or `1'bz`.
- `reg_addr`  out  7: register address of the last accepted frame.
- `reg_data`  out  9: register data of the last accepted frame.
- `reg_wr`  out  1: one-`clk` strobe; `reg_addr`/`reg_data` are valid in that cycle and held afterwards.
- `busy`  out  1: high from a detected START until STOP, abort or reset.
- `addr_nack`  out  1: one-`clk` pulse when an address byte is NACKed.

## Operation
- **Input conditioning.** `i2c_sclk` and `i2c_sdat` each pass through a 2-FF synchronizer. Edge and condition flags are derived from the registered values:
  - START: sdat falls while sclk is high.
  - STOP: sdat rises while sclk is high.
- **States:** IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE.
- **Bit sampling.** The bit counter is 0..7. Data is shifted MSB-first on each detected sclk rising edge.
- **START** from any state: enter ADDR, clear the bit counter and set `busy`. This includes repeated START; any partial frame is discarded.
- **STOP** from any state: enter IDLE, release sdat, clear `busy`. A STOP before ACK_2 produces no `reg_wr`.
- **ADDR, after 8 bits:**
  - If `byte[7:1]==DEV_ADDR` and `byte[0]==0`, enter ACK_A and drive sdat low.
  - Otherwise pulse `addr_nack`, enter IGNORE and leave sdat released.
  - Read requests (R/W=1) are always NACKed.
- **Byte 1.** After 8 bits, latch `byte1` and ACK. The byte is `{addr[6:0], data[8]}`.
- **Byte 2.** After 8 bits, load `reg_addr = byte1[7:1]` and `reg_data = {byte1[0], byte2}`, pulse `reg_wr`, ACK, then enter IGNORE.
- **IGNORE.** Any further bytes are not ACKed (sdat stays released). Only START or STOP leaves this state.
- **ACK window.** Drive low begins on the sclk falling edge that ends bit 8. Release happens on the following sclk falling edge (end of the 9th clock), then move to the next state.
- **Reset values:** sdat released (`z`), `reg_addr=0`, `reg_data=0`, `reg_wr=0`, `busy=0`, `addr_nack=0`, state IDLE.

## Timing
- Pin-to-detect latency: 3 `clk` cycles (2 sync + 1 edge register).
- sclk high and low times must each be at least 4 `clk` periods. sdat setup/hold around sclk edges must be at least 3 `clk` periods.
- The ACK drive-low output is registered, so it changes 1 cycle after the falling edge is detected.
- `reg_wr` asserts in the same cycle that ACK_2 drive begins, for exactly 1 cycle.
- START/STOP are evaluated before data edges. When sclk stays high, sdat changes are conditions, never data.
- Reset is asynchronous and takes effect immediately, including during an ACK; sdat releases combinationally with reset assertion.

## Structure
- Package `wm8731_pkg` holds:
  - the state enum;
  - the default device address constant `WM8731_ADDR = 7'b0011010`;
  - field widths `REG_AW = 7` and `REG_DW = 9`.
- Sub-module `i2c_line_sync` holds the 2-FF synchronizers and the edge/START/STOP detector. Its outputs are `scl_rise`, `scl_fall`, `start_det`, `stop_det` and `sda_s`. It is reusable by `i2cc`.

## Test plan
- **Valid frame.** Send `0x34 0x1E 0x00` + STOP -> ACK on all three 9th clocks; one `reg_wr` with `reg_addr=0x0F`, `reg_data=0x000`; `busy` low after STOP.
- **Address mismatch.** Send `0xAA 0x3C 0xC3` -> `addr_nack` pulses once; sdat never driven; no `reg_wr`.
- **Read request.** Send `0x35` -> NACK and `addr_nack`; no drive for the rest of the frame.
- **Early STOP.** Send `0x34 0x08` then STOP -> two ACKs, no `reg_wr`, IDLE, `busy=0`.
- **Repeated START.** Send `0x34 0x08` + 4 bits, then repeated START, then `0x34 0x08 0x12` -> one `reg_wr` with `reg_addr=0x04`, `reg_data=0x012`.
- **Reset mid-ACK.** Assert reset while ACK_A drives low -> sdat becomes `z` immediately and all outputs take their reset values; a full frame after deassertion is accepted normally.
